// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and opcode indices for the iterative divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bit positions inside the one-hot divide opcode carried through ID/EX/MEM.
    // DIV_W/MOD_W select signed operation; DIV_*/MOD_* select quotient vs remainder.
    localparam int DIV_W    = 0;
    localparam int DIV_WU   = 1;
    localparam int MOD_W    = 2;
    localparam int MOD_WU   = 3;
    localparam int DIV_OP_W = 4;

endpackage

// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response channel between EX, the divider and MEM
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    // Pipeline side: EX issues the request, MEM consumes the response.
    modport master (
        output req_valid, dividend, divisor, is_signed, resp_ready,
        input  req_ready, resp_valid, quotient, remainder
    );

    // Divider side.
    modport slave (
        input  req_valid, dividend, divisor, is_signed, resp_ready,
        output req_ready, resp_valid, quotient, remainder
    );
endinterface

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negate
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Same block serves both directions: magnitude of an operand and re-signing a result.
    assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    div_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t           state;
    div_state_t           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   pr;
    logic [WIDTH-1:0]     divisor_abs;
    logic [WIDTH-1:0]     dividend_orig;
    logic                 q_neg;
    logic                 r_neg;
    logic                 div_zero;
    logic [WIDTH-1:0]     quotient_q;
    logic [WIDTH-1:0]     remainder_q;
    logic                 resp_valid_q;

    logic                 accept;
    logic                 last_step;
    logic [WIDTH-1:0]     dividend_abs_in;
    logic [WIDTH-1:0]     divisor_abs_in;
    logic [WIDTH-1:0]     pr_hi;
    logic [WIDTH-1:0]     pr_lo;
    logic [WIDTH:0]       trial;
    logic                 step_ok;
    logic [2*WIDTH-1:0]   pr_step;
    logic [WIDTH-1:0]     q_fixed;
    logic [WIDTH-1:0]     r_fixed;
    logic [WIDTH-1:0]     quotient_final;
    logic [WIDTH-1:0]     remainder_final;

    assign bus.req_ready  = (state == IDLE) && !flush && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.quotient   = quotient_q;
    assign bus.remainder  = remainder_q;

    assign accept    = bus.req_valid && bus.req_ready;
    assign last_step = (state == CALC) && (cnt == CNT_W'(WIDTH - 1));

    // Operand magnitudes; unsigned ops pass straight through.
    div_sign_fix #(.WIDTH(WIDTH)) u_abs_dividend (
        .neg (bus.is_signed & bus.dividend[WIDTH-1]),
        .a   (bus.dividend),
        .y   (dividend_abs_in)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_divisor (
        .neg (bus.is_signed & bus.divisor[WIDTH-1]),
        .a   (bus.divisor),
        .y   (divisor_abs_in)
    );

    // One restoring step: the shifted-out MSB of the low half joins the partial
    // remainder, and the quotient bit is shifted into the low half as it empties.
    assign pr_hi   = pr[2*WIDTH-1:WIDTH];
    assign pr_lo   = pr[WIDTH-1:0];
    assign trial   = {pr_hi, pr_lo[WIDTH-1]} - {1'b0, divisor_abs};
    assign step_ok = ~trial[WIDTH];
    assign pr_step = step_ok ? {trial[WIDTH-1:0], pr_lo[WIDTH-2:0], 1'b1}
                             : {pr[2*WIDTH-2:0], 1'b0};

    // Sign correction is applied to the final step's result so the registered
    // outputs land on the same edge that raises resp_valid.
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quotient (
        .neg (q_neg),
        .a   (pr_step[WIDTH-1:0]),
        .y   (q_fixed)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_remainder (
        .neg (r_neg),
        .a   (pr_step[2*WIDTH-1:WIDTH]),
        .y   (r_fixed)
    );

    // Divide by zero returns all ones and the untouched dividend, whatever the signedness.
    assign quotient_final  = div_zero ? {WIDTH{1'b1}} : q_fixed;
    assign remainder_final = div_zero ? dividend_orig : r_fixed;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (last_step) state_nxt = DONE;
            DONE: if (resp_valid_q && bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            pr            <= '0;
            divisor_abs   <= '0;
            dividend_orig <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            div_zero      <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            resp_valid_q  <= 1'b0;
        end else if (flush) begin
            cnt          <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pr            <= {{WIDTH{1'b0}}, dividend_abs_in};
                        divisor_abs   <= divisor_abs_in;
                        dividend_orig <= bus.dividend;
                        q_neg         <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg         <= bus.is_signed & bus.dividend[WIDTH-1];
                        div_zero      <= (bus.divisor == '0);
                        cnt           <= '0;
                    end
                end
                CALC: begin
                    pr  <= pr_step;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        quotient_q   <= quotient_final;
                        remainder_q  <= remainder_final;
                        resp_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
